// File: rtl/calc_unit.sv
`default_nettype none
// ============================================================================
// Module      : calc_unit
// Description : Eight-digit decimal calculator core. Accepts edge-detected key
//               codes, performs add/subtract/multiply on non-negative integers
//               and drives eight registered 7-segment digit words. The result
//               is converted to BCD with a serial double-dabble engine.
//               Optional macro SEG_ACTIVE_LOW_EN inverts every segment bit for
//               common-anode displays (blank digit becomes 7'h7F).
// Revision    : 1.0 - initial release
// ============================================================================
module calc_unit #(
    parameter int DIGITS = 8,
    parameter int MAXVAL = 99_999_999
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cmd,
    output logic [6:0] displays [DIGITS-1:0],
    output logic [1:0] status,
    output logic [2:0] EA,
    output logic [2:0] PE
);

    localparam int c_bw   = $clog2(MAXVAL + 1);   // binary operand width
    localparam int c_pw   = 2 * c_bw;             // product width
    localparam int c_dw   = 4 * DIGITS;           // BCD width
    localparam int c_cntw = $clog2(c_bw);

    localparam logic [c_pw-1:0]   c_max      = c_pw'(MAXVAL);
    localparam logic [c_pw-1:0]   c_negmax   = c_pw'(MAXVAL / 10);
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(c_bw - 1);

    localparam logic [1:0] c_op_add = 2'd0;
    localparam logic [1:0] c_op_sub = 2'd1;
    localparam logic [1:0] c_op_mul = 2'd2;

    localparam logic [6:0] c_seg_minus = 7'h40;
    localparam logic [6:0] c_seg_e     = 7'h79;

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_OPERATE = 3'd2,
        S_CONVERT = 3'd3,
        S_RESULT  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_prev_cmd;
    logic [c_bw-1:0]     r_a, r_b, r_mag, r_bin;
    logic [c_dw-1:0]     r_a_bcd, r_b_bcd, r_bcd, w_adj;
    logic [1:0]          r_op, w_op_code;
    logic                r_neg, w_neg, w_ovf;
    logic [c_cntw-1:0]   r_cnt;
    logic [c_pw-1:0]     w_a_ext, w_b_ext, w_mag;
    logic                w_accept, w_digit, w_op, w_clear, w_eq;
    logic                w_a_room, w_b_room;
    logic [c_dw-1:0]     w_src;
    logic                w_src_neg, w_err;
    int                  w_msd;
    logic [6:0]          w_seg  [DIGITS-1:0];
    logic [6:0]          r_disp [DIGITS-1:0];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // A key is taken once, on the first cycle its code differs from the last one.
    assign w_accept  = (cmd != r_prev_cmd) && (cmd != 4'hF);
    assign w_digit   = w_accept && (cmd <= 4'd9);
    assign w_op      = w_accept && (cmd >= 4'hA) && (cmd <= 4'hC);
    assign w_clear   = w_accept && (cmd == 4'hD);
    assign w_eq      = w_accept && (cmd == 4'hE);
    assign w_op_code = (cmd == 4'hA) ? c_op_add : (cmd == 4'hB) ? c_op_sub : c_op_mul;
    // An operand has room while its top BCD digit is still zero.
    assign w_a_room  = (r_a_bcd[c_dw-1 -: 4] == 4'd0);
    assign w_b_room  = (r_b_bcd[c_dw-1 -: 4] == 4'd0);
    assign w_a_ext   = c_pw'(r_a);
    assign w_b_ext   = c_pw'(r_b);

    // Arithmetic as sign + magnitude, with range check for both signs.
    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (r_op)
            c_op_add: w_mag = w_a_ext + w_b_ext;
            c_op_sub: begin
                if (w_a_ext >= w_b_ext) begin
                    w_mag = w_a_ext - w_b_ext;
                end else begin
                    w_mag = w_b_ext - w_a_ext;
                    w_neg = 1'b1;
                end
            end
            default:  w_mag = w_a_ext * w_b_ext;
        endcase
        w_ovf = (w_mag > c_max) || (w_neg && (w_mag > c_negmax));
    end

    // Double-dabble add-3 correction applied before each shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_ENTER_A;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; clear overrides every state.
    always_comb begin
        w_next = r_state;
        if (w_clear) begin
            w_next = S_ENTER_A;
        end else begin
            case (r_state)
                S_ENTER_A: if (w_op) w_next = S_ENTER_B;
                S_ENTER_B: if (w_eq) w_next = S_OPERATE;
                S_OPERATE: w_next = w_ovf ? S_ERROR : S_CONVERT;
                S_CONVERT: if (r_cnt == c_cnt_last) w_next = S_RESULT;
                S_RESULT: begin
                    if (w_digit)             w_next = S_ENTER_A;
                    else if (w_op && !r_neg) w_next = S_ENTER_B;
                end
                S_ERROR:   w_next = S_ERROR;
                default:   w_next = S_ENTER_A;
            endcase
        end
    end

    // Operand entry, arithmetic capture and serial BCD conversion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev_cmd <= 4'hF;
            r_a        <= '0;
            r_b        <= '0;
            r_a_bcd    <= '0;
            r_b_bcd    <= '0;
            r_op       <= c_op_add;
            r_mag      <= '0;
            r_neg      <= 1'b0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
        end else begin
            r_prev_cmd <= cmd;
            if (w_clear) begin
                r_a     <= '0;
                r_b     <= '0;
                r_a_bcd <= '0;
                r_b_bcd <= '0;
                r_op    <= c_op_add;
                r_mag   <= '0;
                r_neg   <= 1'b0;
                r_bin   <= '0;
                r_bcd   <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_ENTER_A: begin
                        if (w_digit && w_a_room) begin
                            r_a     <= c_bw'(r_a * 10) + c_bw'(cmd);
                            r_a_bcd <= {r_a_bcd[c_dw-5:0], cmd};
                        end else if (w_op) begin
                            r_op <= w_op_code;
                        end
                    end
                    S_ENTER_B: begin
                        if (w_digit && w_b_room) begin
                            r_b     <= c_bw'(r_b * 10) + c_bw'(cmd);
                            r_b_bcd <= {r_b_bcd[c_dw-5:0], cmd};
                        end
                    end
                    S_OPERATE: begin
                        r_mag <= w_mag[c_bw-1:0];
                        r_neg <= w_neg;
                        r_bin <= w_mag[c_bw-1:0];
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                    S_CONVERT: begin
                        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                        r_cnt          <= r_cnt + 1'b1;
                    end
                    S_RESULT: begin
                        if (w_digit) begin
                            r_a     <= c_bw'(cmd);
                            r_a_bcd <= c_dw'(cmd);
                            r_b     <= '0;
                            r_b_bcd <= '0;
                        end else if (w_op && !r_neg) begin
                            r_a     <= r_mag;
                            r_a_bcd <= r_bcd;
                            r_op    <= w_op_code;
                            r_b     <= '0;
                            r_b_bcd <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pick the value to show and render it with leading-zero blanking and sign.
    always_comb begin
        w_src     = '0;
        w_src_neg = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            S_ENTER_A: w_src = r_a_bcd;
            S_ENTER_B: w_src = r_b_bcd;
            S_RESULT: begin
                w_src     = r_bcd;
                w_src_neg = r_neg;
            end
            S_ERROR:   w_err = 1'b1;
            default:   ;
        endcase
        w_msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_src[4*i +: 4] != 4'd0) w_msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            w_seg[i] = (i <= w_msd) ? seg7(w_src[4*i +: 4]) : 7'h00;
            if (w_src_neg && (i == w_msd + 1)) w_seg[i] = c_seg_minus;
            if (w_err) w_seg[i] = (i == 0) ? c_seg_e : 7'h00;
        end
    end

    // Display register; holds its contents while the core is busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_disp[i] <= (i == 0) ? 7'h3F : 7'h00;
            end
        end else if ((r_state != S_OPERATE) && (r_state != S_CONVERT)) begin
            r_disp <= w_seg;
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
`ifdef SEG_ACTIVE_LOW_EN
            assign displays[gi] = ~r_disp[gi];
`else
            assign displays[gi] = r_disp[gi];
`endif
        end
    endgenerate

    // Status derived from the current state.
    always_comb begin
        case (r_state)
            S_OPERATE, S_CONVERT: status = 2'b01;
            S_ERROR:              status = 2'b10;
            default:              status = 2'b00;
        endcase
    end

    assign EA = r_state;
    assign PE = w_next;

endmodule
`default_nettype wire

// File: tb/tb_calc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_unit
// Description : Directed testbench for calc_unit with hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_unit;

    logic       clock;
    logic       reset;
    logic [3:0] cmd;
    logic [6:0] displays [7:0];
    logic [1:0] status;
    logic [2:0] EA;
    logic [2:0] PE;

    int total = 0;
    int bad   = 0;

    calc_unit dut (
        .clock    (clock),
        .reset    (reset),
        .cmd      (cmd),
        .displays (displays),
        .status   (status),
        .EA       (EA),
        .PE       (PE)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] char_seg(input byte c);
        case (c)
            "0": char_seg = 7'h3F;
            "1": char_seg = 7'h06;
            "2": char_seg = 7'h5B;
            "3": char_seg = 7'h4F;
            "4": char_seg = 7'h66;
            "5": char_seg = 7'h6D;
            "6": char_seg = 7'h7D;
            "7": char_seg = 7'h07;
            "8": char_seg = 7'h7F;
            "9": char_seg = 7'h6F;
            "-": char_seg = 7'h40;
            "E": char_seg = 7'h79;
            default: char_seg = 7'h00;
        endcase
    endfunction

    // Right-aligned text -> packed expected display word (digit 0 in low bits).
    function automatic logic [55:0] exp_disp(input string s);
        logic [55:0] r;
        int n;
        r = '0;
        n = s.len();
        for (int i = 0; i < n; i++) begin
            r[i*7 +: 7] = char_seg(s[n-1-i]);
        end
`ifdef SEG_ACTIVE_LOW_EN
        r = ~r;
`endif
        return r;
    endfunction

    function automatic logic [55:0] act_disp();
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[i*7 +: 7] = displays[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        cmd = k;
        repeat (10) @(negedge clock);
        cmd = 4'hF;
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_ea(input logic [2:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (EA !== target && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 64'(EA), 64'(target));
    endtask

    initial begin
        reset = 1'b1;
        cmd   = 4'hF;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        chk("reset_ea", 64'(EA), 64'd0);
        chk("reset_status", 64'(status), 64'd0);
        chk("reset_pe", 64'(PE), 64'd0);
        chk("reset_disp", 64'(act_disp()), 64'(exp_disp("0")));

        // 123 + 1 = 124
        press(4'd1); press(4'd2); press(4'd3);
        chk("enter_a_disp", 64'(act_disp()), 64'(exp_disp("123")));
        cmd = 4'hA;
        #1;
        chk("pe_comb", 64'(PE), 64'd1);
        chk("ea_before_edge", 64'(EA), 64'd0);
        repeat (10) @(negedge clock);
        cmd = 4'hF;
        repeat (2) @(negedge clock);
        chk("enter_b_ea", 64'(EA), 64'd1);
        chk("enter_b_zero", 64'(act_disp()), 64'(exp_disp("0")));
        press(4'd1);
        press(4'hE);
        chk("busy_ea", 64'(EA), 64'd3);
        chk("busy_status", 64'(status), 64'd1);
        wait_ea(3'd4, 40, "add_wait");
        @(negedge clock);
        chk("add_status", 64'(status), 64'd0);
        chk("add_disp", 64'(act_disp()), 64'(exp_disp("124")));

        // 50 - 15 = 35
        press(4'd5); press(4'd0); press(4'hB); press(4'd1); press(4'd5); press(4'hE);
        wait_ea(3'd4, 40, "sub_wait");
        @(negedge clock);
        chk("sub_disp", 64'(act_disp()), 64'(exp_disp("35")));
        chk("sub_status", 64'(status), 64'd0);

        // 6 * 2 = 12, then + 3 = 15
        press(4'd6); press(4'hC); press(4'd2); press(4'hE);
        wait_ea(3'd4, 40, "mul_wait");
        @(negedge clock);
        chk("mul_disp", 64'(act_disp()), 64'(exp_disp("12")));
        press(4'hA); press(4'd3); press(4'hE);
        wait_ea(3'd4, 40, "chain_wait");
        @(negedge clock);
        chk("chain_disp", 64'(act_disp()), 64'(exp_disp("15")));

        // 1 - 9 = -8; operator on negative result is ignored
        press(4'd1); press(4'hB); press(4'd9); press(4'hE);
        wait_ea(3'd4, 40, "neg_wait");
        @(negedge clock);
        chk("neg_disp", 64'(act_disp()), 64'(exp_disp("-8")));
        press(4'hA);
        chk("neg_op_ignored", 64'(EA), 64'd4);

        // 99999999 * 99 overflows
        for (int i = 0; i < 8; i++) press(4'd9);
        chk("max_a_disp", 64'(act_disp()), 64'(exp_disp("99999999")));
        press(4'hC); press(4'd9); press(4'd9); press(4'hE);
        wait_ea(3'd5, 40, "err_wait");
        @(negedge clock);
        chk("err_status", 64'(status), 64'd2);
        chk("err_disp", 64'(act_disp()), 64'(exp_disp("E")));
        chk("err_pe_hold", 64'(PE), 64'd5);
        press(4'hD);
        chk("clear_ea", 64'(EA), 64'd0);
        chk("clear_disp", 64'(act_disp()), 64'(exp_disp("0")));

        // Held key taken once
        cmd = 4'd7;
        repeat (30) @(negedge clock);
        cmd = 4'hF;
        repeat (2) @(negedge clock);
        chk("hold_disp", 64'(act_disp()), 64'(exp_disp("7")));

        // Nine digits: only the first eight kept
        press(4'hD);
        for (int i = 1; i <= 9; i++) press(4'(i));
        chk("limit_disp", 64'(act_disp()), 64'(exp_disp("12345678")));
        chk("limit_ea", 64'(EA), 64'd0);

        // Reset in the middle of conversion
        press(4'hD);
        press(4'd5); press(4'hA); press(4'd5); press(4'hE);
        chk("mid_conv_ea", 64'(EA), 64'd3);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_ea", 64'(EA), 64'd0);
        chk("async_rst_status", 64'(status), 64'd0);
        chk("async_rst_disp", 64'(act_disp()), 64'(exp_disp("0")));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ea", 64'(EA), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
